diff_tx_serializer: RTL and testbench

Digital serializer that drives the transmit end of the team's differential serial link: accepts 16-bit words over a valid/ready handshake and shifts them out MSB-first with a forwarded bit clock and a word-start marker. It sits between the design's digital core and the output drivers. The output drivers convert tx_data and tx_clk into the differential pairs that a matching deserializer samples on the rising edge of the forwarded clock.

---
 rtl/diff_tx_serializer.sv | 185 ++++++++++++++++++
 tb/tb_diff_tx_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_tx_serializer.sv
// diff_tx_serializer: 16-bit word serializer for the differential TX link.
// Words arrive over valid/ready into a one-deep holding register. They are
// shifted out MSB-first, two clk cycles per bit, with a forwarded bit clock
// (tx_clk) and a frame marker on bit 15. All outputs are registered.
// Optional feature: define DIFF_TX_PRBS_EN to compile in a PRBS7 test source
// selected by prbs_en. Without the macro, prbs_en is ignored.
module diff_tx_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        prbs_en,
   output logic        tx_data,
   output logic        tx_clk,
   output logic        tx_frame,
   output logic        busy
);

   // state | meaning
   // IDLE  | link quiet, all lines low, waiting for a held word (or PRBS)
   // SHIFT | streaming bits; phase 0 = tx_clk low, phase 1 = tx_clk high
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic [15:0] shift_q, shift_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        phase_q, phase_d;
   logic        tx_data_q, tx_data_d;
   logic        tx_clk_q, tx_clk_d;
   logic        tx_frame_q, tx_frame_d;
   logic        busy_q, busy_d;

   logic        accept;
   logic        word_end;
   logic        at_boundary;
   logic        next_bit;
   logic        start_word;
   logic        src_prbs;
   logic        cur_prbs;
   logic        prbs_bit;

`ifdef DIFF_TX_PRBS_EN
   logic [6:0]  prbs_q, prbs_d;
   logic        prbs_mode_q, prbs_mode_d;

   assign prbs_bit = prbs_q[6] ^ prbs_q[5];
   assign src_prbs = prbs_en;
   assign cur_prbs = prbs_mode_q;
   // The holding register stays frozen while the PRBS source owns the link.
   assign in_ready = ~hold_full_q & ~prbs_mode_q;
`else
   logic        prbs_en_unused;

   assign prbs_en_unused = prbs_en;
   assign prbs_bit       = 1'b0;
   assign src_prbs       = 1'b0;
   assign cur_prbs       = 1'b0;
   assign in_ready       = ~hold_full_q;
`endif

   assign accept      = in_valid & in_ready;
   assign word_end    = (state_q == SHIFT) & phase_q & (cnt_q == 4'd0);
   assign next_bit    = (state_q == SHIFT) & phase_q & (cnt_q != 4'd0);
   assign at_boundary = (state_q == IDLE) | word_end;
   assign start_word  = at_boundary & (hold_full_q | src_prbs);

   // Next-state, datapath and next registered-output values.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      tx_data_d   = tx_data_q;
      tx_clk_d    = tx_clk_q;
      tx_frame_d  = tx_frame_q;

      if (start_word) begin
         // Launch bit 15 of a new word, with no gap after the previous one.
         state_d    = SHIFT;
         cnt_d      = 4'd15;
         phase_d    = 1'b0;
         tx_clk_d   = 1'b0;
         tx_frame_d = 1'b1;
         if (src_prbs) begin
            tx_data_d = prbs_bit;
         end else begin
            shift_d     = hold_q;
            tx_data_d   = hold_q[15];
            hold_full_d = 1'b0;
         end
      end else if (next_bit) begin
         // tx_clk falls: the only moment data is allowed to change.
         cnt_d      = cnt_q - 4'd1;
         phase_d    = 1'b0;
         tx_clk_d   = 1'b0;
         tx_frame_d = 1'b0;
         if (cur_prbs) begin
            tx_data_d = prbs_bit;
         end else begin
            shift_d   = {shift_q[14:0], 1'b0};
            tx_data_d = shift_q[14];
         end
      end else if ((state_q == SHIFT) && !phase_q) begin
         // Second half of the bit: receiver samples on this rising edge.
         phase_d  = 1'b1;
         tx_clk_d = 1'b1;
      end else begin
         state_d    = IDLE;
         tx_data_d  = 1'b0;
         tx_clk_d   = 1'b0;
         tx_frame_d = 1'b0;
      end

      // A new word may land in the same cycle the old one moves to shift.
      if (accept) begin
         hold_d      = in_data;
         hold_full_d = 1'b1;
      end

      busy_d = (state_d == SHIFT);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= 4'd15;
         phase_q     <= 1'b0;
         tx_data_q   <= 1'b0;
         tx_clk_q    <= 1'b0;
         tx_frame_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         tx_data_q   <= tx_data_d;
         tx_clk_q    <= tx_clk_d;
         tx_frame_q  <= tx_frame_d;
         busy_q      <= busy_d;
      end
   end

`ifdef DIFF_TX_PRBS_EN
   // PRBS7 source: one LFSR step per launched PRBS bit; mode latched per word.
   always_comb begin
      prbs_d      = prbs_q;
      prbs_mode_d = prbs_mode_q;
      if (start_word | word_end) begin
         prbs_mode_d = start_word & prbs_en;
      end
      if ((start_word & prbs_en) | (next_bit & prbs_mode_q)) begin
         prbs_d = {prbs_q[5:0], prbs_bit};
      end
   end

   // PRBS registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prbs_q      <= 7'h7F;
         prbs_mode_q <= 1'b0;
      end else begin
         prbs_q      <= prbs_d;
         prbs_mode_q <= prbs_mode_d;
      end
   end
`endif

   assign tx_data  = tx_data_q;
   assign tx_clk   = tx_clk_q;
   assign tx_frame = tx_frame_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_diff_tx_serializer.sv
// Bench for diff_tx_serializer: a receive-side model samples tx_data on tx_clk
// rising edges and checks recovered words and frame alignment against the
// queue of accepted words; a per-cycle process checks line rules.
module tb_diff_tx_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        prbs_en;
   logic        tx_data;
   logic        tx_clk;
   logic        tx_frame;
   logic        busy;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic        rx_bits[$];

   always #5 clk = ~clk;

   diff_tx_serializer dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .prbs_en  (prbs_en),
      .tx_data  (tx_data),
      .tx_clk   (tx_clk),
      .tx_frame (tx_frame),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h, nothing acceptable at %0t", name, act, $time);
   endtask

   // Words accepted on this edge enter the expected stream.
   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) exp_q.push_back(in_data);
   end

   // Receive-side deserializer: sample on forwarded-clock rising edges.
   logic        rx_prev_clk = 1'b0;
   int          rx_cnt = 0;
   logic [15:0] rx_w = '0;
   always @(negedge clk) begin
      if (rst) begin
         rx_cnt      = 0;
         rx_prev_clk = 1'b0;
      end else begin
         if (tx_clk && !rx_prev_clk) begin
            chk("frame_align", 32'(tx_frame), 32'(rx_cnt == 0));
            rx_bits.push_back(tx_data);
            rx_w = {rx_w[14:0], tx_data};
            rx_cnt++;
            if (rx_cnt == 16) begin
               rx_cnt = 0;
               if (exp_q.size() == 0) fail("rx_unexpected_word", 32'(rx_w));
               else chk("rx_word", 32'(rx_w), 32'(exp_q.pop_front()));
            end
         end
         rx_prev_clk = tx_clk;
      end
   end

   // Per-cycle line rules.
   logic p_busy = 1'b0, p_clk = 1'b0, p_data = 1'b0, p_frame = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (!busy) begin
            chk("idle_lines", 32'({tx_data, tx_clk, tx_frame}), 32'd0);
         end else begin
            if (p_busy) chk("clk_toggle", 32'(tx_clk), 32'(!p_clk));
            if (tx_data !== p_data || tx_frame !== p_frame)
               chk("change_on_fall", 32'(tx_clk), 32'd0);
         end
      end
      p_busy  = busy;
      p_clk   = tx_clk;
      p_data  = tx_data;
      p_frame = tx_frame;
   end

   task automatic send(input logic [15:0] w);
      bit ok = 0;
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (!ok) fail("send_timeout", 32'(w));
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 5000; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         @(negedge clk);
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   logic b[1:80], f[1:80], c[1:80], d[1:80], r[1:80];

   initial begin
      int          cnt;
      int          first;
      int          last;
      logic [15:0] w;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      prbs_en  = 1'b0;

`ifdef DIFF_TX_PRBS_EN
      begin
         int s = 127;
         prbs_en = 1'b1;
         for (int k = 0; k < 25; k++) begin
            w = '0;
            for (int j = 0; j < 16; j++) begin
               int nb = ((s >> 6) ^ (s >> 5)) & 1;
               s = ((s << 1) | nb) & 127;
               w = {w[14:0], nb[0]};
            end
            exp_q.push_back(w);
         end
         repeat (3) @(negedge clk);
         rst = 1'b0;
         for (int i = 0; i < 2000 && rx_bits.size() < 300; i++) @(negedge clk);
         chk("prbs_in_ready", 32'(in_ready), 32'd0);
         if (rx_bits.size() < 300) begin
            fail("prbs_bit_timeout", 32'(rx_bits.size()));
         end else begin
            int bad = 0;
            w = '0;
            for (int j = 0; j < 16; j++) w = {w[14:0], rx_bits[j]};
            chk("prbs_first_word", 32'(w), 32'h020C);
            for (int j = 0; j < 127; j++) if (rx_bits[j] !== rx_bits[j + 127]) bad++;
            chk("prbs_period_127", 32'(bad), 32'd0);
         end
         rst     = 1'b1;
         prbs_en = 1'b0;
         @(negedge clk);
         exp_q.delete();
         rx_bits.delete();
      end
`endif

      repeat (2) @(negedge clk);
      chk("rst_tx_data",  32'(tx_data),  32'd0);
      chk("rst_tx_clk",   32'(tx_clk),   32'd0);
      chk("rst_tx_frame", 32'(tx_frame), 32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Single word, cycle-exact timing.
      send(16'hA5C3);
      chk("a5_in_ready_low", 32'(in_ready), 32'd0);
      chk("a5_still_idle",   32'(busy),     32'd0);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         b[i] = busy; f[i] = tx_frame; c[i] = tx_clk; d[i] = tx_data;
      end
      cnt = 0;
      for (int i = 1; i <= 40; i++) cnt += int'(b[i]);
      chk("a5_busy_cycles", 32'(cnt), 32'd32);
      cnt = 0;
      for (int i = 1; i <= 40; i++) cnt += int'(f[i]);
      chk("a5_frame_cycles", 32'(cnt), 32'd2);
      chk("a5_first_cycle", 32'({b[1], f[1], c[1], d[1]}), 32'b1101);
      chk("a5_second_clk",  32'(c[2]), 32'd1);
      chk("a5_end_idle",    32'({b[33], c[33]}), 32'd0);
      w = '0;
      for (int k = 0; k < 16; k++) w = {w[14:0], d[2 + 2 * k]};
      chk("a5_word_bits", 32'(w), 32'hA5C3);
      drain("a5_drain");

      // Back-to-back words with in_valid held.
      send(16'hFFFF);
      chk("b2b_in_ready_drop", 32'(in_ready), 32'd0);
      fork
         send(16'h0001);
         for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            b[i] = busy; f[i] = tx_frame; r[i] = in_ready;
         end
      join
      cnt = 0; first = 0; last = 0;
      for (int i = 1; i <= 80; i++) begin
         if (b[i]) begin
            cnt++;
            if (first == 0) first = i;
            last = i;
         end
      end
      chk("b2b_busy_cycles", 32'(cnt), 32'd64);
      chk("b2b_no_gap", 32'(last - first + 1), 32'd64);
      cnt = 0;
      for (int i = 1; i <= 80; i++) cnt += int'(f[i]);
      chk("b2b_frame_cycles", 32'(cnt), 32'd4);
      chk("b2b_frame_second", 32'({f[33], f[34], f[35]}), 32'b110);
      chk("b2b_ready_seq", 32'({r[1], r[2], r[32], r[33]}), 32'b1001);
      drain("b2b_drain");

      // Reset mid-word with a second word held.
      send(16'hFFFF);
      send(16'h1234);
      repeat (16) @(negedge clk);
      chk("rst_pre_state", 32'({busy, tx_clk, tx_data}), 32'b111);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_lines", 32'({busy, tx_clk, tx_data, tx_frame}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("rst_in_ready_after", 32'(in_ready), 32'd1);
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         cnt += int'(busy);
      end
      chk("rst_held_discarded", 32'(cnt), 32'd0);

      // Randomized stream with random idle gaps.
      for (int k = 0; k < 100; k++) begin
`ifndef DIFF_TX_PRBS_EN
         prbs_en = 1'($urandom_range(0, 1));
`endif
         send(16'($urandom()));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      drain("rand_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
